// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Each requester owns a registered response slot with its own valid/ready handshake.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [15:0] r0_A,
   input  logic [15:0] r0_B,
   input  logic [4:0]  r0_Op,
   input  logic        r0_sign,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [15:0] r1_A,
   input  logic [15:0] r1_B,
   input  logic [4:0]  r1_Op,
   input  logic        r1_sign,
   output logic [15:0] alu_A,
   output logic [15:0] alu_B,
   output logic [4:0]  alu_Op,
   output logic        alu_sign,
   input  logic [15:0] alu_Out,
   input  logic        alu_OFL,
   input  logic        alu_Zero,
   output logic        s0_valid,
   input  logic        s0_ready,
   output logic [15:0] s0_data,
   output logic        s0_ofl,
   output logic        s0_zero,
   output logic        s1_valid,
   input  logic        s1_ready,
   output logic [15:0] s1_data,
   output logic        s1_ofl,
   output logic        s1_zero,
   output logic        last_grant
);

   localparam logic [4:0] OP_NOP = 5'd28;

   logic [1:0]  req_valid;
   logic [1:0]  req_sign;
   logic [15:0] req_a  [2];
   logic [15:0] req_b  [2];
   logic [4:0]  req_op [2];
   logic [1:0]  rsp_ready;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ofl;
   logic [1:0]  rsp_zero;
   logic [15:0] rsp_data [2];
   logic [1:0]  elig;
   logic [1:0]  gnt;
   logic        last_grant_q, last_grant_d;

   assign req_valid = {r1_valid, r0_valid};
   assign req_sign  = {r1_sign, r0_sign};
   assign rsp_ready = {s1_ready, s0_ready};
   assign req_a[0]  = r0_A;
   assign req_a[1]  = r1_A;
   assign req_b[0]  = r0_B;
   assign req_b[1]  = r1_B;
   assign req_op[0] = r0_Op;
   assign req_op[1] = r1_Op;

   // A requester whose response slot is draining this cycle may issue again.
   always_comb begin
      elig = req_valid & (~rsp_valid | rsp_ready);
      gnt  = 2'b00;
      if (rst_n) begin
         gnt[0] = elig[0] & (~elig[1] | last_grant_q);
         gnt[1] = elig[1] & (~elig[0] | ~last_grant_q);
      end
   end

   always_comb begin
      alu_A    = '0;
      alu_B    = '0;
      alu_Op   = OP_NOP;
      alu_sign = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) begin
            alu_A    = req_a[i];
            alu_B    = req_b[i];
            alu_Op   = req_op[i];
            alu_sign = req_sign[i];
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic        valid_q, valid_d;
      logic        ofl_q, ofl_d;
      logic        zero_q, zero_d;
      logic [15:0] data_q, data_d;

      // A new accept wins over a drain, so back-to-back results leave no bubble.
      always_comb begin
         valid_d = gnt[gi] | (valid_q & ~rsp_ready[gi]);
         data_d  = gnt[gi] ? alu_Out  : data_q;
         ofl_d   = gnt[gi] ? alu_OFL  : ofl_q;
         zero_d  = gnt[gi] ? alu_Zero : zero_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ofl_q   <= 1'b0;
            zero_q  <= 1'b0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ofl_q   <= ofl_d;
            zero_q  <= zero_d;
         end
      end

      assign rsp_valid[gi] = valid_q;
      assign rsp_data[gi]  = data_q;
      assign rsp_ofl[gi]   = ofl_q;
      assign rsp_zero[gi]  = zero_q;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt[1]) begin
         last_grant_d = 1'b1;
      end else if (gnt[0]) begin
         last_grant_d = 1'b0;
      end
   end

   // Resetting to 1 makes requester 0 win the first contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign r0_ready   = gnt[0];
   assign r1_ready   = gnt[1];
   assign s0_valid   = rsp_valid[0];
   assign s0_data    = rsp_data[0];
   assign s0_ofl     = rsp_ofl[0];
   assign s0_zero    = rsp_zero[0];
   assign s1_valid   = rsp_valid[1];
   assign s1_data    = rsp_data[1];
   assign s1_ofl     = rsp_ofl[1];
   assign s1_zero    = rsp_zero[1];
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: emulated ALU, directed vector table, hand sequences and
// randomized traffic checked against a transaction-level model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0_valid, r1_valid, r0_ready, r1_ready, r0_sign, r1_sign;
   logic [15:0] r0_A, r0_B, r1_A, r1_B;
   logic [4:0]  r0_Op, r1_Op;
   logic [15:0] alu_A, alu_B, alu_Out;
   logic [4:0]  alu_Op;
   logic        alu_sign, alu_OFL, alu_Zero;
   logic        s0_valid, s0_ready, s0_ofl, s0_zero;
   logic        s1_valid, s1_ready, s1_ofl, s1_zero;
   logic [15:0] s0_data, s1_data;
   logic        last_grant;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_A(r0_A), .r0_B(r0_B),
      .r0_Op(r0_Op), .r0_sign(r0_sign),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_A(r1_A), .r1_B(r1_B),
      .r1_Op(r1_Op), .r1_sign(r1_sign),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_sign(alu_sign),
      .alu_Out(alu_Out), .alu_OFL(alu_OFL), .alu_Zero(alu_Zero),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
      .s0_ofl(s0_ofl), .s0_zero(s0_zero),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
      .s1_ofl(s1_ofl), .s1_zero(s1_zero),
      .last_grant(last_grant)
   );

   // Emulated shared ALU: returns {ofl, zero, out}.
   function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op, input logic sg);
      logic [16:0] w;
      logic [15:0] o;
      logic        v;
      v = 1'b0;
      w = '0;
      case (op)
         5'd0: begin
            w = 17'(a) + 17'(b);
            o = w[15:0];
            v = sg ? ((a[15] == b[15]) && (o[15] != a[15])) : w[16];
         end
         5'd1: begin
            w = 17'(a) - 17'(b);
            o = w[15:0];
            v = sg ? ((a[15] != b[15]) && (o[15] != a[15])) : w[16];
         end
         5'd2: o = a | b;
         5'd3: o = a & b;
         5'd4: o = a ^ b;
         default: begin
            o = a ^ {b[14:0], b[15]} ^ {11'd0, op};
            v = op[0] & b[0];
         end
      endcase
      return {v, (o == 16'd0), o};
   endfunction

   assign {alu_OFL, alu_Zero, alu_Out} = alu_f(alu_A, alu_B, alu_Op, alu_sign);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level model: one pending response record per requester.
   logic        m_sv [2];
   logic [15:0] m_sd [2];
   logic        m_so [2];
   logic        m_sz [2];
   logic        m_lg;
   int          m_wait [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_sv[i] = 1'b0; m_sd[i] = '0; m_so[i] = 1'b0; m_sz[i] = 1'b0; m_wait[i] = 0;
      end
      m_lg = 1'b1;
   endtask

   task automatic model_cycle();
      logic        rv [2];
      logic        sr [2];
      logic        rs [2];
      logic        el [2];
      logic [15:0] ra [2];
      logic [15:0] rb [2];
      logic [4:0]  ro [2];
      logic [17:0] res;
      int          q[$];
      int          g;
      rv[0] = r0_valid; rv[1] = r1_valid; sr[0] = s0_ready; sr[1] = s1_ready;
      ra[0] = r0_A; ra[1] = r1_A; rb[0] = r0_B; rb[1] = r1_B;
      ro[0] = r0_Op; ro[1] = r1_Op; rs[0] = r0_sign; rs[1] = r1_sign;
      for (int i = 0; i < 2; i++) begin
         el[i] = rv[i] && (!m_sv[i] || sr[i]);
         if (el[i]) q.push_back(i);
      end
      g = -1;
      if (q.size() == 1) g = q[0];
      else if (q.size() == 2) g = (m_lg == 1'b1) ? 0 : 1;

      chk("m_r0_ready", r0_ready, g == 0);
      chk("m_r1_ready", r1_ready, g == 1);
      if (g >= 0) begin
         chk("m_alu_A", alu_A, ra[g]);
         chk("m_alu_B", alu_B, rb[g]);
         chk("m_alu_Op", alu_Op, ro[g]);
         chk("m_alu_sign", alu_sign, rs[g]);
      end else begin
         chk("m_alu_A_idle", alu_A, 0);
         chk("m_alu_B_idle", alu_B, 0);
         chk("m_alu_Op_idle", alu_Op, 28);
         chk("m_alu_sign_idle", alu_sign, 0);
      end
      chk("m_s0_valid", s0_valid, m_sv[0]);
      chk("m_s0_data", s0_data, m_sd[0]);
      chk("m_s0_ofl", s0_ofl, m_so[0]);
      chk("m_s0_zero", s0_zero, m_sz[0]);
      chk("m_s1_valid", s1_valid, m_sv[1]);
      chk("m_s1_data", s1_data, m_sd[1]);
      chk("m_s1_ofl", s1_ofl, m_so[1]);
      chk("m_s1_zero", s1_zero, m_sz[1]);
      chk("m_last_grant", last_grant, m_lg);

      for (int i = 0; i < 2; i++) begin
         if (el[i]) begin
            if (i == 0) m_wait[i] = r0_ready ? 0 : m_wait[i] + 1;
            else        m_wait[i] = r1_ready ? 0 : m_wait[i] + 1;
            chk("starvation_bound", m_wait[i] < 2, 1'b1);
         end else begin
            m_wait[i] = 0;
         end
      end

      for (int i = 0; i < 2; i++) begin
         if (g == i) begin
            res = alu_f(ra[i], rb[i], ro[i], rs[i]);
            m_sv[i] = 1'b1; m_sd[i] = res[15:0]; m_sz[i] = res[16]; m_so[i] = res[17];
         end else if (m_sv[i] && sr[i]) begin
            m_sv[i] = 1'b0;
         end
      end
      if (g >= 0) m_lg = g[0];
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v0, v1, sr0, sr1;
      logic [15:0] a0, b0;
      logic [4:0]  op0;
      logic [15:0] a1, b1;
      logic [4:0]  op1;
      logic        e_rdy0, e_rdy1;
      logic [4:0]  e_op;
      logic        e_s0v;
      logic [15:0] e_s0d;
      logic        e_s1v;
      logic [15:0] e_s1d;
      logic        e_lg;
   } vec_t;

   vec_t vecs [13];

   initial begin
      vecs[0]  = '{1,1,1,1, 16'h0001,16'h0001,5'd0, 16'h00F0,16'h000F,5'd2, 1,0,5'd0,  0,16'h0000,0,16'h0000,1};
      vecs[1]  = '{1,1,1,1, 16'h0001,16'h0001,5'd0, 16'h00F0,16'h000F,5'd2, 0,1,5'd2,  1,16'h0002,0,16'h0000,0};
      vecs[2]  = '{0,0,1,1, 16'h0000,16'h0000,5'd0, 16'h0000,16'h0000,5'd0, 0,0,5'd28, 0,16'h0002,1,16'h00FF,1};
      vecs[3]  = '{1,0,1,1, 16'h0003,16'h0004,5'd0, 16'h0000,16'h0000,5'd0, 1,0,5'd0,  0,16'h0002,0,16'h00FF,1};
      vecs[4]  = '{0,0,1,1, 16'h0000,16'h0000,5'd0, 16'h0000,16'h0000,5'd0, 0,0,5'd28, 1,16'h0007,0,16'h00FF,0};
      vecs[5]  = '{0,0,1,1, 16'h0000,16'h0000,5'd0, 16'h0000,16'h0000,5'd0, 0,0,5'd28, 0,16'h0007,0,16'h00FF,0};
      vecs[6]  = '{1,1,0,1, 16'h000A,16'h0005,5'd0, 16'h0001,16'h0002,5'd2, 0,1,5'd2,  0,16'h0007,0,16'h00FF,0};
      vecs[7]  = '{1,1,0,1, 16'h000A,16'h0005,5'd0, 16'h0001,16'h0002,5'd2, 1,0,5'd0,  0,16'h0007,1,16'h0003,1};
      vecs[8]  = '{1,1,0,1, 16'h0020,16'h0030,5'd0, 16'h0004,16'h0008,5'd2, 0,1,5'd2,  1,16'h000F,0,16'h0003,0};
      vecs[9]  = '{1,1,0,1, 16'h0020,16'h0030,5'd0, 16'h0010,16'h0020,5'd2, 0,1,5'd2,  1,16'h000F,1,16'h000C,1};
      vecs[10] = '{1,0,1,1, 16'h0020,16'h0030,5'd0, 16'h0000,16'h0000,5'd0, 1,0,5'd0,  1,16'h000F,1,16'h0030,1};
      vecs[11] = '{0,0,1,1, 16'h0000,16'h0000,5'd0, 16'h0000,16'h0000,5'd0, 0,0,5'd28, 1,16'h0050,0,16'h0030,0};
      vecs[12] = '{0,0,1,1, 16'h0000,16'h0000,5'd0, 16'h0000,16'h0000,5'd0, 0,0,5'd28, 0,16'h0050,0,16'h0030,0};
   end

   task automatic rand_inputs();
      r0_valid = ($urandom_range(0, 3) != 0);
      r1_valid = ($urandom_range(0, 3) != 0);
      s0_ready = ($urandom_range(0, 9) < 7);
      s1_ready = ($urandom_range(0, 9) < 7);
      r0_A = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      r1_A = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      r0_B = 16'($urandom); r1_B = 16'($urandom);
      r0_Op = 5'($urandom); r1_Op = 5'($urandom);
      r0_sign = 1'($urandom); r1_sign = 1'($urandom);
   endtask

   initial begin
      r0_valid = 0; r1_valid = 0; r0_sign = 0; r1_sign = 0;
      r0_A = 0; r0_B = 0; r1_A = 0; r1_B = 0; r0_Op = 0; r1_Op = 0;
      s0_ready = 0; s1_ready = 0;
      model_reset();

      // Reset: outputs idle even with requests present.
      #2;
      r0_valid = 1; r1_valid = 1; s0_ready = 1; s1_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_alu_Op", alu_Op, 28);
      chk("rst_alu_A", alu_A, 0);
      chk("rst_s0_valid", s0_valid, 0);
      chk("rst_s1_valid", s1_valid, 0);
      chk("rst_s0_data", s0_data, 0);
      chk("rst_last_grant", last_grant, 1);
      rst_n = 1;

      // Directed vector table: contention, single op, backpressure.
      for (int k = 0; k < 13; k++) begin
         r0_valid = vecs[k].v0; r1_valid = vecs[k].v1;
         s0_ready = vecs[k].sr0; s1_ready = vecs[k].sr1;
         r0_A = vecs[k].a0; r0_B = vecs[k].b0; r0_Op = vecs[k].op0; r0_sign = 0;
         r1_A = vecs[k].a1; r1_B = vecs[k].b1; r1_Op = vecs[k].op1; r1_sign = 0;
         @(negedge clk);
         chk($sformatf("vec%0d_r0_ready", k), r0_ready, vecs[k].e_rdy0);
         chk($sformatf("vec%0d_r1_ready", k), r1_ready, vecs[k].e_rdy1);
         chk($sformatf("vec%0d_alu_Op", k), alu_Op, vecs[k].e_op);
         chk($sformatf("vec%0d_s0_valid", k), s0_valid, vecs[k].e_s0v);
         chk($sformatf("vec%0d_s0_data", k), s0_data, vecs[k].e_s0d);
         chk($sformatf("vec%0d_s1_valid", k), s1_valid, vecs[k].e_s1v);
         chk($sformatf("vec%0d_s1_data", k), s1_data, vecs[k].e_s1d);
         chk($sformatf("vec%0d_last_grant", k), last_grant, vecs[k].e_lg);
         model_cycle();
         @(posedge clk);
         #1;
      end

      // Flags: signed overflow on SUB, then zero result.
      r0_valid = 0; r1_valid = 1; s1_ready = 1;
      r1_A = 16'h0001; r1_B = 16'h8000; r1_Op = 5'd1; r1_sign = 1;
      tick();
      r1_A = 16'h0000; r1_B = 16'hFFFF; r1_Op = 5'd3; r1_sign = 0;
      @(negedge clk);
      chk("flag_s1_ofl", s1_ofl, 1);
      chk("flag_s1_data", s1_data, 16'h8001);
      chk("flag_s1_zero_clear", s1_zero, 0);
      model_cycle();
      @(posedge clk);
      #1;
      r1_valid = 0;
      @(negedge clk);
      chk("flag_s1_zero", s1_zero, 1);
      chk("flag_s1_ofl_clear", s1_ofl, 0);
      model_cycle();
      @(posedge clk);
      #1;

      // Idle for ten cycles.
      r0_valid = 0; r1_valid = 0;
      for (int k = 0; k < 10; k++) begin
         s0_ready = 1'($urandom); s1_ready = 1'($urandom);
         tick();
      end

      // Sustained contention with responses always drained.
      r0_valid = 1; r1_valid = 1; s0_ready = 1; s1_ready = 1;
      for (int k = 0; k < 8; k++) begin
         r0_A = 16'(k); r0_B = 16'h0100; r0_Op = 5'd0;
         r1_A = 16'(k); r1_B = 16'h0F00; r1_Op = 5'd2;
         tick();
      end

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         rand_inputs();
         tick();
      end

      // Reset mid-stream with both responses pending.
      r0_valid = 1; r1_valid = 1; s0_ready = 0; s1_ready = 0;
      r0_A = 16'h1111; r0_B = 16'h2222; r0_Op = 5'd0;
      r1_A = 16'h3333; r1_B = 16'h0F0F; r1_Op = 5'd3;
      tick();
      tick();
      chk("prerst_s0_valid", s0_valid, 1);
      chk("prerst_s1_valid", s1_valid, 1);
      rst_n = 0;
      #1;
      chk("midrst_s0_valid", s0_valid, 0);
      chk("midrst_s1_valid", s1_valid, 0);
      chk("midrst_s0_data", s0_data, 0);
      chk("midrst_s1_data", s1_data, 0);
      chk("midrst_last_grant", last_grant, 1);
      chk("midrst_r0_ready", r0_ready, 0);
      chk("midrst_r1_ready", r1_ready, 0);
      chk("midrst_alu_Op", alu_Op, 28);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      s0_ready = 1; s1_ready = 1;
      #1;
      chk("postrst_r0_ready", r0_ready, 1);
      chk("postrst_r1_ready", r1_ready, 0);
      model_cycle();
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
